// File: rtl/seven_segment_reader.sv
// Loop-back monitor for a multiplexed, active-low seven-segment display.
// Each digit is sampled once per scan visit and debounced across visits.
// Each newly committed code is offered on a single-entry valid/ready output
// register, and digits are served round-robin.
module seven_segment_reader #(
  parameter int DIGITS        = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STABLE_COUNT  = 3,
  localparam int IDX_W        = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        sevenSegmentActiveLow,
  input  logic [DIGITS-1:0] anodeActiveLow,
  output logic              outValid,
  input  logic              outReady,
  output logic [IDX_W-1:0]  outDigitIndex,
  output logic [4:0]        outCode
);

  localparam logic [4:0] CODE_P     = 5'h11;
  localparam logic [4:0] CODE_BLANK = 5'h12;
  localparam logic [4:0] CODE_BAD   = 5'h1F;

  // Active-low gfedcba pattern to digit code.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] code;
    case (seg)
      7'b1000000: code = 5'h00;
      7'b1111001: code = 5'h01;
      7'b0100100: code = 5'h02;
      7'b0110000: code = 5'h03;
      7'b0011001: code = 5'h04;
      7'b0010010: code = 5'h05;
      7'b0000010: code = 5'h06;
      7'b1111000: code = 5'h07;
      7'b0000000: code = 5'h08;
      7'b0010000: code = 5'h09;
      7'b0001000: code = 5'h0A;
      7'b0000011: code = 5'h0B;
      7'b1000110: code = 5'h0C;
      7'b0100001: code = 5'h0D;
      7'b0000110: code = 5'h0E;
      7'b0001110: code = 5'h0F;
      7'b0001100: code = CODE_P;
      7'b1111111: code = CODE_BLANK;
      default:    code = CODE_BAD;
    endcase
    return code;
  endfunction

  logic [DIGITS-1:0] sel_low;
  logic              anode_valid;
  logic [DIGITS-1:0] prev_anode;
  logic [3:0]        settle_cnt;
  logic              sample_fire;
  logic [IDX_W-1:0]  sample_idx;
  logic [4:0]        sample_code;

  logic [4:0]        cand      [DIGITS];
  logic [3:0]        match_cnt [DIGITS];
  logic [4:0]        committed [DIGITS];
  logic [DIGITS-1:0] pending;
  logic [DIGITS-1:0] pending_next;
  logic [3:0]        next_cnt;
  logic              commit_fire;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              out_load;
  logic              out_take;

  assign sel_low     = ~anodeActiveLow;
  assign anode_valid = $onehot(sel_low);
  assign sample_code = decode(sevenSegmentActiveLow);

  // The settle counter is loaded on the first edge of a visit and counts down
  // on each edge that sees the same pattern. The single sample falls on its
  // terminal count, and the counter then idles at zero until the pattern changes.
  assign sample_fire = anode_valid && (anodeActiveLow == prev_anode) && (settle_cnt == 4'd1);

  // Encode the selected digit position from the one-hot-low anode bus.
  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_low[IDX_W'(i)]) sample_idx = IDX_W'(i);
    end
  end

  // Track visits: remember last anode pattern and run the settle timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_anode <= '1;
      settle_cnt <= '0;
    end else begin
      prev_anode <= anodeActiveLow;
      if (!anode_valid)
        settle_cnt <= '0;
      else if (anodeActiveLow != prev_anode)
        settle_cnt <= 4'(SETTLE_CYCLES);
      else if (settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Debounce arithmetic for the digit being sampled this edge.
  always_comb begin
    if (sample_code == cand[sample_idx]) begin
      if (match_cnt[sample_idx] >= 4'(STABLE_COUNT))
        next_cnt = 4'(STABLE_COUNT);
      else
        next_cnt = match_cnt[sample_idx] + 4'd1;
    end else begin
      next_cnt = 4'd1;
    end
    commit_fire = sample_fire && (next_cnt == 4'(STABLE_COUNT)) &&
                  (sample_code != committed[sample_idx]);
  end

  // Per-digit candidate, match count and committed code.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        cand[i]      <= CODE_BLANK;
        match_cnt[i] <= '0;
        committed[i] <= CODE_BLANK;
      end
    end else if (sample_fire) begin
      cand[sample_idx]      <= sample_code;
      match_cnt[sample_idx] <= next_cnt;
      if (commit_fire) committed[sample_idx] <= sample_code;
    end
  end

  // Round-robin search for the next pending digit after the last one served.
  always_comb begin : rr_select
    int pos;
    pos        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= DIGITS; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= DIGITS) pos = pos - DIGITS;
      if (!pick_found && pending[IDX_W'(pos)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(pos);
      end
    end
  end

  assign out_load = !outValid || outReady;
  assign out_take = out_load && pick_found;

  // A commit that lands on the same edge as the clear wins, so the newer value
  // is not lost. The output register picks that value up on a later load.
  always_comb begin
    pending_next = pending;
    if (out_take) pending_next[pick_idx] = 1'b0;
    if (commit_fire) pending_next[sample_idx] = 1'b1;
  end

  // Single-entry output register and pending flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid      <= 1'b0;
      outDigitIndex <= '0;
      outCode       <= '0;
      rr_ptr        <= IDX_W'(DIGITS - 1);
      pending       <= '0;
    end else begin
      pending <= pending_next;
      if (out_load) begin
        outValid <= pick_found;
        if (pick_found) begin
          outDigitIndex <= pick_idx;
          outCode       <= committed[pick_idx];
          rr_ptr        <= pick_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader. It holds a behavioural model based on run
// lengths and per-digit records, compares against it every cycle, and checks
// the directed scenarios against hand-computed words.
module tb_seven_segment_reader;
  localparam int DIGITS = 4;
  localparam int SETTLE = 2;
  localparam int STABLE = 3;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;
  localparam logic [6:0] SEG_A      = 7'b0001000;
  localparam logic [6:0] SEG_P      = 7'b0001100;
  localparam logic [6:0] SEG_GLITCH = 7'b0101010;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic              clk = 1'b0;
  logic              reset;
  logic [6:0]        sevenSegmentActiveLow;
  logic [DIGITS-1:0] anodeActiveLow;
  logic              outValid;
  logic              outReady;
  logic [1:0]        outDigitIndex;
  logic [4:0]        outCode;

  int n_total = 0;
  int n_pass  = 0;
  int wlog[$];

  seven_segment_reader #(
    .DIGITS(DIGITS), .SETTLE_CYCLES(SETTLE), .STABLE_COUNT(STABLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sevenSegmentActiveLow(sevenSegmentActiveLow),
    .anodeActiveLow(anodeActiveLow),
    .outValid(outValid),
    .outReady(outReady),
    .outDigitIndex(outDigitIndex),
    .outCode(outCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int ref_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (s == HEX_GLYPH[i]) return i;
    if (s == SEG_P) return 'h11;
    if (s == SEG_BLANK) return 'h12;
    return 'h1F;
  endfunction

  // Behavioural model
  bit                m_started = 0;
  int                m_run;
  logic [DIGITS-1:0] m_prev;
  int                m_cand [DIGITS];
  int                m_cnt  [DIGITS];
  int                m_comm [DIGITS];
  bit                m_pend [DIGITS];
  bit                m_valid;
  int                m_idx, m_code, m_last;

  task automatic model_step();
    int  nlow, d, c, pick;
    bit  found;
    m_started = 1;
    if (reset) begin
      m_run = 0; m_prev = '1; m_valid = 0; m_idx = 0; m_code = 0; m_last = DIGITS - 1;
      for (int i = 0; i < DIGITS; i++) begin
        m_cand[i] = 'h12; m_cnt[i] = 0; m_comm[i] = 'h12; m_pend[i] = 0;
      end
      return;
    end
    nlow = $countones(~anodeActiveLow);
    if (nlow == 1 && anodeActiveLow == m_prev) m_run++;
    else if (nlow == 1) m_run = 1;
    else m_run = 0;
    m_prev = anodeActiveLow;
    if (!m_valid || outReady) begin
      found = 0; pick = 0;
      for (int k = 1; k <= DIGITS; k++)
        if (!found && m_pend[(m_last + k) % DIGITS]) begin
          found = 1; pick = (m_last + k) % DIGITS;
        end
      m_valid = found;
      if (found) begin
        m_idx = pick; m_code = m_comm[pick]; m_last = pick; m_pend[pick] = 0;
      end
    end
    if (m_run == SETTLE + 1) begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (!anodeActiveLow[i]) d = i;
      c = ref_decode(sevenSegmentActiveLow);
      if (c == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > STABLE) ? STABLE : m_cnt[d] + 1;
      else begin
        m_cand[d] = c; m_cnt[d] = 1;
      end
      if (m_cnt[d] == STABLE && m_cand[d] != m_comm[d]) begin
        m_comm[d] = m_cand[d]; m_pend[d] = 1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("model_outValid", outValid, m_valid);
      if (m_valid) begin
        chk("model_outDigitIndex", outDigitIndex, m_idx);
        chk("model_outCode", outCode, m_code);
      end
    end
  end

  // Record accepted words as index*256+code.
  always @(negedge clk) begin
    if (!reset && outValid === 1'b1 && outReady)
      wlog.push_back(int'(outDigitIndex) * 256 + int'(outCode));
  end

  task automatic check_log(input string name, input int n, input int w0, input int w1,
                           input int w2, input int w3);
    int e[4];
    e = '{w0, w1, w2, w3};
    chk({name, "_count"}, wlog.size(), n);
    for (int i = 0; i < n; i++)
      if (i < wlog.size()) chk(name, wlog[i], e[i]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic visit(input int d, input logic [6:0] p, input int hold);
    anodeActiveLow = ~(4'b0001 << d);
    sevenSegmentActiveLow = p;
    cyc(hold);
  endtask

  task automatic round4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input int hold);
    visit(0, p0, hold); visit(1, p1, hold); visit(2, p2, hold); visit(3, p3, hold);
  endtask

  task automatic idle(input int n);
    anodeActiveLow = '1;
    sevenSegmentActiveLow = SEG_BLANK;
    cyc(n);
  endtask

  initial begin
    logic [6:0] pool [5];
    pool = '{SEG_1, SEG_2, SEG_8, SEG_BLANK, SEG_GLITCH};
    reset = 1'b1; outReady = 1'b1;
    anodeActiveLow = '1; sevenSegmentActiveLow = SEG_BLANK;
    cyc(3);
    chk("reset_outValid", outValid, 0);
    chk("reset_outCode", outCode, 0);
    chk("reset_outDigitIndex", outDigitIndex, 0);
    reset = 1'b0;

    // Blank display matches the reset commit value.
    wlog.delete();
    for (int r = 0; r < 10; r++) round4(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, 4);
    idle(3);
    check_log("blank_scan", 0, 0, 0, 0, 0);

    // "1 2 A P": third visit commits; word appears one cycle after the commit edge.
    wlog.delete();
    for (int r = 0; r < 2; r++) round4(SEG_1, SEG_2, SEG_A, SEG_P, 4);
    anodeActiveLow = 4'b1110; sevenSegmentActiveLow = SEG_1;
    cyc(3);
    chk("commit_edge_outValid", outValid, 0);
    cyc(1);
    chk("word_outValid", outValid, 1);
    chk("word_outDigitIndex", outDigitIndex, 0);
    chk("word_outCode", outCode, 'h01);
    visit(1, SEG_2, 4); visit(2, SEG_A, 4); visit(3, SEG_P, 4);
    idle(3);
    check_log("digits_12AP", 4, 'h001, 'h102, 'h20A, 'h311);

    // Digit 2 alternating 8/9 never stabilises.
    wlog.delete();
    for (int r = 0; r < 20; r++) round4(SEG_1, SEG_2, (r % 2 == 1) ? SEG_9 : SEG_8, SEG_P, 4);
    idle(3);
    check_log("alt_89", 0, 0, 0, 0, 0);

    // Too-short holds and two-bits-low selects never sample.
    wlog.delete();
    for (int r = 0; r < 5; r++) round4(SEG_5, SEG_5, SEG_5, SEG_5, 2);
    for (int i = 0; i < 6; i++) begin
      anodeActiveLow = (i % 2 == 1) ? 4'b1100 : 4'b1001;
      sevenSegmentActiveLow = SEG_5;
      cyc(4);
    end
    idle(3);
    check_log("short_and_double", 0, 0, 0, 0, 0);

    // Unknown pattern decodes to 0x1F.
    wlog.delete();
    for (int r = 0; r < 3; r++) round4(SEG_1, SEG_GLITCH, SEG_A, SEG_P, 4);
    idle(3);
    check_log("glitch", 1, 'h11F, 0, 0, 0);

    // Backpressure: first word held; digit 0 keeps only its newest code.
    wlog.delete();
    outReady = 1'b0;
    for (int r = 0; r < 3; r++) round4(SEG_5, SEG_GLITCH, SEG_A, SEG_6, 4);
    chk("held_outValid", outValid, 1);
    chk("held_outDigitIndex", outDigitIndex, 0);
    chk("held_outCode", outCode, 'h05);
    for (int r = 0; r < 3; r++) round4(SEG_7, SEG_GLITCH, SEG_A, SEG_6, 4);
    chk("still_outValid", outValid, 1);
    chk("still_outDigitIndex", outDigitIndex, 0);
    chk("still_outCode", outCode, 'h05);
    check_log("held_no_handshake", 0, 0, 0, 0, 0);
    outReady = 1'b1;
    idle(6);
    check_log("drain", 3, 'h005, 'h306, 'h007, 0);

    // Reset while a word is waiting.
    outReady = 1'b0;
    for (int r = 0; r < 3; r++) round4(SEG_3, SEG_GLITCH, SEG_A, SEG_6, 4);
    idle(2);
    chk("pre_reset_outValid", outValid, 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_reset_outValid", outValid, 0);
    chk("mid_reset_outCode", outCode, 0);
    chk("mid_reset_outDigitIndex", outDigitIndex, 0);
    reset = 1'b0; outReady = 1'b1;
    wlog.delete();
    for (int r = 0; r < 2; r++) round4(SEG_3, SEG_GLITCH, SEG_A, SEG_6, 4);
    idle(2);
    check_log("after_reset_2rounds", 0, 0, 0, 0, 0);
    round4(SEG_3, SEG_GLITCH, SEG_A, SEG_6, 4);
    idle(4);
    check_log("after_reset_3rounds", 4, 'h003, 'h11F, 'h20A, 'h306);

    // Randomised scanning, holds, invalid selects and backpressure.
    for (int v = 0; v < 300; v++) begin
      if ($urandom_range(0, 9) == 0) anodeActiveLow = 4'($urandom_range(0, 15));
      else anodeActiveLow = ~(4'b0001 << $urandom_range(0, DIGITS - 1));
      if ($urandom_range(0, 15) == 0) sevenSegmentActiveLow = 7'($urandom_range(0, 127));
      else sevenSegmentActiveLow = pool[$urandom_range(0, 4)];
      outReady = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(1, 6));
    end
    outReady = 1'b1;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Captures the multiplexed, active-low seven-segment bus that the timer display drivers produce and decodes it back into digit codes (hex 0-F plus the A, P and blank indicator glyphs). Each digit position is debounced across scan visits, and a code is emitted on a valid/ready stream only when a digit's stable value changes. The block sits on the display side of the timer as a loop-back monitor that feeds self-check and readback logic.

## Interface
- DIGITS, 4, number of multiplexed digit positions (2..8)
- SETTLE_CYCLES, 2, cycles the anode pattern must be held before the segments are sampled (1..15)
- STABLE_COUNT, 3, consecutive identical samples of a digit required to commit it (1..15)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sevenSegmentActiveLow  in  7  segment bus, bit0=a … bit6=g, 0 = lit
- anodeActiveLow  in  DIGITS  digit select, exactly one bit low = valid select
- outValid  out  1  output word valid
- outReady  in  1  consumer accepts the word when high together with outValid
- outDigitIndex  out  clog2(DIGITS)  digit position of the word
- outCode  out  5  decoded code for that position

## Operation
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000 (code 0x0A, which also serves the A glyph), b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - P=0001100 → 0x11; blank=1111111 → 0x12; any other pattern → 0x1F
- Visit tracking: a registered copy of the previous anodeActiveLow plus a settle counter.
  - A visit starts on the first edge that sees a valid one-hot-low pattern differing from the previous one.
  - Exactly one sample is taken per visit, on the edge where the same valid pattern has been seen for SETTLE_CYCLES+1 consecutive edges.
  - A visit ends on any change of pattern. An invalid pattern (zero or more than one bit low) ends the visit and produces no sample.
  - A pattern held indefinitely produces only one sample.
- Per-digit state: candidate code, match count (saturating at STABLE_COUNT), committed code, pending flag.
  - Sample equals candidate: count increments.
  - Sample differs from candidate: candidate = sample, count = 1.
  - On the same sampling edge, if the updated count equals STABLE_COUNT and the candidate differs from the committed code, the committed code takes the candidate and pending is set.
  - Equal to committed: nothing is emitted.
- Output register, single entry:
  - Loads when outValid=0, or when outValid=1 and outReady=1.
  - Selects the next pending digit round-robin, starting at the index after the last emitted one.
  - Loads that digit's current committed code and clears its pending flag in the same edge.
  - A digit that re-commits while pending carries only its newest value; intermediate values are dropped by design.
  - A digit that re-commits on the edge its pending flag is being cleared stays pending.
- The output word is stable while outValid=1 and outReady=0.

## Timing
- Reset values:
  - outValid=0, outDigitIndex=0, outCode=0x00
  - all candidates and committed codes = 0x12, counts=0, pending=0
  - previous-anode register = all ones, settle counter=0, round-robin pointer = last index = DIGITS-1, so digit 0 is served first
- Reset asserted mid-operation drops the in-flight word and all pending state on the next edge.
- Sample-to-commit: same edge. Commit-to-outValid: outValid is high in the cycle after the commit edge when the output register is free.
- With outReady tied high, one word per cycle is delivered while any digit is pending.
- Minimum pattern hold for a sample: SETTLE_CYCLES+1 cycles. Minimum visits to commit a new value: STABLE_COUNT.

## Test plan
- Reset then scan 4 digits showing blank for 10 rounds (SETTLE=2, hold 4 cycles) -> outValid stays 0 (committed blank equals reset value).
- Scan "1","2","A","P" with outReady=1 -> after the 3rd visit of each digit, words (0,0x01),(1,0x02),(2,0x0A),(3,0x11) arrive in order, each 1 cycle after its commit edge.
- Digit 2 alternates 8/9 on successive visits for 20 rounds -> no word for digit 2; the count never reaches 3.
- Anode held for only 2 cycles, or with two bits low -> no samples and no output; a glitch pattern 0101010 held 3 visits -> code 0x1F.
- outReady=0 while digits 0 and 3 commit, then digit 0 changes again -> outValid holds the first word unchanged; after ready, digit 3 is emitted, then digit 0 with its newest code only.
- Reset pulsed while outValid=1 -> next cycle outValid=0, outCode=0x00; the same display must re-commit after 3 visits.
